clk_div_multi: RTL

Parametrised multi-channel clock divider: the next generation of the single fixed-ratio divider. It produces NUM_CH independent square-wave outputs from one input clock, each with a runtime-programmable half-period, a per-channel enable and a one-cycle tick strobe. A common sync input phase-aligns all channels. It sits between the board oscillator and slow consumers such as shift registers, LED scanners and debouncers.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_multi_if.sv | 29 ++
 rtl/clk_div_chan.sv | 87 ++++++++
 rtl/clk_div_multi.sv | 43 ++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// The width, default half-period and simulation half-period live here so every file agrees.
package clk_div_pkg;

    localparam int CNT_W_DEFAULT  = 32;
    localparam int DEFAULT_HP_VAL = 100000000;
    localparam int SIM_HP         = 4;

    // Per-channel operating mode, decoded in priority order each cycle.
    typedef enum logic [1:0] {
        MODE_RST,
        MODE_SYNC,
        MODE_OFF,
        MODE_RUN
    } chan_mode_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and output bundle of the multi-channel clock divider.
// load is a one-cycle strobe with no back-pressure: ch_sel and div_in are taken on every clkin edge where load=1.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int NUM_CH = 4
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              load;
    logic [SEL_W-1:0]  ch_sel;
    logic [CNT_W-1:0]  div_in;
    logic [NUM_CH-1:0] clkout;
    logic [NUM_CH-1:0] tick;

    modport master (
        output en, sync, load, ch_sel, div_in,
        input  clkout, tick
    );

    modport slave (
        input  en, sync, load, ch_sel, div_in,
        output clkout, tick
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending half-period registers,
// and the registered clkout/tick flops.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W      = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DEFAULT_HP = CNT_W'(DEFAULT_HP_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load_hit,
    input  logic [CNT_W-1:0] div_in,
    output logic             clkout,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp_act;
    logic [CNT_W-1:0] hp_pend;
    logic             wrap;
    chan_mode_e       mode;

    always_comb begin
        mode = MODE_RUN;
        if (rst) begin
            mode = MODE_RST;
        end else if (sync) begin
            mode = MODE_SYNC;
        end else if (!en) begin
            mode = MODE_OFF;
        end
    end

    // cnt never exceeds hp_act, so the increment cannot overflow even at the all-ones half-period.
    assign wrap = (cnt >= hp_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clkout  <= 1'b0;
            tick    <= 1'b0;
            hp_act  <= DEFAULT_HP;
            hp_pend <= DEFAULT_HP;
        end else begin
            case (mode)
                MODE_SYNC: begin
                    cnt    <= '0;
                    clkout <= 1'b0;
                    tick   <= 1'b0;
                    if (load_hit) begin
                        hp_act  <= div_in;
                        hp_pend <= div_in;
                    end else begin
                        hp_act  <= hp_pend;
                    end
                end
                MODE_OFF: begin
                    cnt    <= '0;
                    clkout <= 1'b0;
                    tick   <= 1'b0;
                    if (load_hit) begin
                        hp_act  <= div_in;
                        hp_pend <= div_in;
                    end
                end
                default: begin
                    // A load on a wrap edge lands in hp_pend after hp_act has already taken the old value.
                    if (load_hit) begin
                        hp_pend <= div_in;
                    end
                    if (wrap) begin
                        cnt    <= '0;
                        clkout <= ~clkout;
                        tick   <= 1'b1;
                        hp_act <= hp_pend;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        tick   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider top: decodes ch_sel into per-channel load strobes
// and replicates one divider channel per output.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int               CNT_W      = CNT_W_DEFAULT,
    parameter int               NUM_CH     = 4,
    parameter logic [CNT_W-1:0] DEFAULT_HP = CNT_W'(DEFAULT_HP_VAL)
) (
    input  logic            clkin,
    input  logic            rst,
    clk_div_multi_if.slave  bus
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] load_hit;
    logic [NUM_CH-1:0] clkout_v;
    logic [NUM_CH-1:0] tick_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Only indices below NUM_CH are decoded, so an out-of-range ch_sel hits nothing.
        assign load_hit[i] = bus.load && (bus.ch_sel == SEL_W'(i));

        clk_div_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_HP (DEFAULT_HP)
        ) u_chan (
            .clk      (clkin),
            .rst      (rst),
            .en       (bus.en[i]),
            .sync     (bus.sync),
            .load_hit (load_hit[i]),
            .div_in   (bus.div_in),
            .clkout   (clkout_v[i]),
            .tick     (tick_v[i])
        );
    end

    assign bus.clkout = clkout_v;
    assign bus.tick   = tick_v;

endmodule
